// File: rtl/dds_param_bank.sv
// Shadow/live parameter bank for the DDS. CPU writes land in shadow registers and move to the live
// outputs together on a symbol boundary. A free-running symbol timer also steps an MSB-first code serialiser.
module dds_param_bank #(
  parameter int SYM_DIV = 9766
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  sel,
  input  logic [15:0] wdata,
  input  logic        commit,
  output logic [23:0] fc,
  output logic [23:0] fs,
  output logic [3:0]  ma,
  output logic [15:0] fd,
  output logic [15:0] pd,
  output logic [15:0] seq_code,
  output logic        code_bit,
  output logic        sym_tick,
  output logic        pending,
  output logic        applied,
  output logic        err
);

  localparam int CW = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_DIV - 1);

  logic [23:0] fc_sh_q, fc_sh_d, fs_sh_q, fs_sh_d, fc_q, fc_d, fs_q, fs_d;
  logic [3:0]  ma_sh_q, ma_sh_d, ma_q, ma_d;
  logic [15:0] fd_sh_q, fd_sh_d, pd_sh_q, pd_sh_d, seq_sh_q, seq_sh_d;
  logic [15:0] fd_q, fd_d, pd_q, pd_d, seq_q, seq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        pending_q, pending_d, applied_q, applied_d, err_q, err_d;
  logic        field_err, apply;

  assign sym_tick = (cnt_q == CNT_LAST);
  assign apply    = sym_tick & pending_q;

  always_comb begin
    fc_sh_d   = fc_sh_q;
    fs_sh_d   = fs_sh_q;
    ma_sh_d   = ma_sh_q;
    fd_sh_d   = fd_sh_q;
    pd_sh_d   = pd_sh_q;
    seq_sh_d  = seq_sh_q;
    field_err = 1'b0;
    if (wr_en) begin
      case (sel)
        3'd0: fc_sh_d[15:0] = wdata;
        3'd1: begin
          fc_sh_d[23:16] = wdata[7:0];
          field_err      = |wdata[15:8];
        end
        3'd2: fs_sh_d[15:0] = wdata;
        3'd3: begin
          fs_sh_d[23:16] = wdata[7:0];
          field_err      = |wdata[15:8];
        end
        3'd4: begin
          ma_sh_d   = wdata[3:0];
          field_err = |wdata[15:4];
        end
        3'd5: fd_sh_d  = wdata;
        3'd6: pd_sh_d  = wdata;
        default: seq_sh_d = wdata;
      endcase
    end
  end

  always_comb begin
    // Live copies load from the pre-edge shadow, so a write on the apply edge stays in shadow.
    fc_d  = apply ? fc_sh_q  : fc_q;
    fs_d  = apply ? fs_sh_q  : fs_q;
    ma_d  = apply ? ma_sh_q  : ma_q;
    fd_d  = apply ? fd_sh_q  : fd_q;
    pd_d  = apply ? pd_sh_q  : pd_q;
    seq_d = apply ? seq_sh_q : seq_q;

    cnt_d = sym_tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (apply)         idx_d = 4'hF;
    else if (sym_tick) idx_d = idx_q - 4'd1;

    pending_d = ~apply & (pending_q | commit);
    applied_d = apply;
    // A bad-field write on the apply edge concerns the new shadow contents, so it still sets err.
    err_d     = (err_q & ~apply) | field_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_sh_q   <= '0;
      fs_sh_q   <= '0;
      ma_sh_q   <= '0;
      fd_sh_q   <= '0;
      pd_sh_q   <= '0;
      seq_sh_q  <= '0;
      fc_q      <= '0;
      fs_q      <= '0;
      ma_q      <= '0;
      fd_q      <= '0;
      pd_q      <= '0;
      seq_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= 4'hF;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fc_sh_q   <= fc_sh_d;
      fs_sh_q   <= fs_sh_d;
      ma_sh_q   <= ma_sh_d;
      fd_sh_q   <= fd_sh_d;
      pd_sh_q   <= pd_sh_d;
      seq_sh_q  <= seq_sh_d;
      fc_q      <= fc_d;
      fs_q      <= fs_d;
      ma_q      <= ma_d;
      fd_q      <= fd_d;
      pd_q      <= pd_d;
      seq_q     <= seq_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      err_q     <= err_d;
    end
  end

  assign fc       = fc_q;
  assign fs       = fs_q;
  assign ma       = ma_q;
  assign fd       = fd_q;
  assign pd       = pd_q;
  assign seq_code = seq_q;
  assign code_bit = seq_q[idx_q];
  assign pending  = pending_q;
  assign applied  = applied_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dds_param_bank.sv
// Directed bench for dds_param_bank with SYM_DIV=10: table of write/commit records plus
// hand sequences for timer period, serialiser order, commit-on-tick, write-on-apply and reset.
module tb_dds_param_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  sel;
  logic [15:0] wdata;
  logic        commit;
  logic [23:0] fc, fs;
  logic [3:0]  ma;
  logic [15:0] fd, pd, seq_code;
  logic        code_bit, sym_tick, pending, applied, err;

  int n_tests = 0;
  int n_fail  = 0;

  dds_param_bank #(.SYM_DIV(10)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .sel(sel), .wdata(wdata), .commit(commit),
    .fc(fc), .fs(fs), .ma(ma), .fd(fd), .pd(pd), .seq_code(seq_code),
    .code_bit(code_bit), .sym_tick(sym_tick), .pending(pending), .applied(applied), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sa;
    logic [15:0] da;
    logic [2:0]  sb;
    logic [15:0] db;
    logic        err_e;
    logic [23:0] fc_e;
    logic [23:0] fs_e;
    logic [3:0]  ma_e;
    logic [15:0] fd_e;
    logic [15:0] pd_e;
    logic [15:0] seq_e;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [15:0] d);
    wr_en = 1'b1;
    sel   = s;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!sym_tick && n < 30) begin
      tick();
      n++;
    end
    if (!sym_tick) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick: sym_tick not seen within 30 cycles");
    end
  endtask

  initial begin
    int n;
    int seen;
    logic [23:0] prev_fc;
    logic [15:0] seq_v;

    vecs[0] = '{3'd0, 16'h5678, 3'd1, 16'h0012, 1'b0, 24'h125678, 24'h000000, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{3'd4, 16'h00F3, 3'd4, 16'h00F3, 1'b1, 24'h125678, 24'h000000, 4'h3, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{3'd2, 16'hBEEF, 3'd3, 16'h0034, 1'b0, 24'h125678, 24'h34BEEF, 4'h3, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{3'd5, 16'h1234, 3'd6, 16'h5555, 1'b0, 24'h125678, 24'h34BEEF, 4'h3, 16'h1234, 16'h5555, 16'h0000};
    vecs[4] = '{3'd7, 16'h8001, 3'd1, 16'h01FF, 1'b1, 24'hFF5678, 24'h34BEEF, 4'h3, 16'h1234, 16'h5555, 16'h8001};

    rst = 1'b1; wr_en = 1'b0; sel = '0; wdata = '0; commit = 1'b0;
    tick(); tick();
    chk("rst_fc", fc, 0);
    chk("rst_fs", fs, 0);
    chk("rst_ma", ma, 0);
    chk("rst_fd", fd, 0);
    chk("rst_pd", pd, 0);
    chk("rst_seq", seq_code, 0);
    chk("rst_flags", {code_bit, sym_tick, pending, applied, err}, 0);
    rst = 1'b0;

    // First tick lands in the 10th cycle after release, then one every 10.
    n = 0;
    while (!sym_tick && n < 30) begin tick(); n++; end
    chk("first_tick_cycle", n + 1, 10);
    tick();
    chk("tick_one_cycle", sym_tick, 0);
    n = 1;
    while (!sym_tick && n < 30) begin tick(); n++; end
    chk("tick_period", n, 10);

    prev_fc = 24'h0;
    for (int i = 0; i < 5; i++) begin
      wr(vecs[i].sa, vecs[i].da);
      wr(vecs[i].sb, vecs[i].db);
      chk($sformatf("v%0d_err_after_wr", i), err, vecs[i].err_e);
      do_commit();
      chk($sformatf("v%0d_pending", i), pending, 1);
      chk($sformatf("v%0d_fc_held", i), fc, prev_fc);
      wait_tick();
      tick();
      chk($sformatf("v%0d_applied", i), applied, 1);
      chk($sformatf("v%0d_fc", i), fc, vecs[i].fc_e);
      chk($sformatf("v%0d_fs", i), fs, vecs[i].fs_e);
      chk($sformatf("v%0d_ma", i), ma, vecs[i].ma_e);
      chk($sformatf("v%0d_fd", i), fd, vecs[i].fd_e);
      chk($sformatf("v%0d_pd", i), pd, vecs[i].pd_e);
      chk($sformatf("v%0d_seq", i), seq_code, vecs[i].seq_e);
      chk($sformatf("v%0d_err_clr", i), {pending, err}, 0);
      tick();
      chk($sformatf("v%0d_applied_pulse", i), applied, 0);
      prev_fc = vecs[i].fc_e;
    end

    // seq 0x8001 is live with idx at 15: bits 1, fourteen 0s, 1, then 1 again.
    seq_v = 16'h8001;
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("code_bit_%0d", k), code_bit, seq_v[15 - (k % 16)]);
      wait_tick();
      tick();
    end

    // Commit in a tick cycle with pending clear: apply waits for the following tick.
    wr(3'd6, 16'h0F0F);
    wait_tick();
    do_commit();
    chk("cot_no_apply", applied, 0);
    chk("cot_pending", pending, 1);
    chk("cot_pd_old", pd, 16'h5555);
    n = 0;
    while (!sym_tick && n < 30) begin tick(); n++; end
    chk("cot_apply_delay", n, 9);
    wr(3'd6, 16'hAAAA);
    chk("woa_applied", applied, 1);
    chk("woa_pd_old_shadow", pd, 16'h0F0F);
    chk("woa_pending", pending, 0);
    do_commit();
    wait_tick();
    tick();
    chk("woa_next_applied", applied, 1);
    chk("woa_pd_new", pd, 16'hAAAA);

    // Reset while a commit is pending discards it.
    tick();
    wr(3'd0, 16'h1111);
    do_commit();
    chk("rp_pending", pending, 1);
    #2 rst = 1'b1;
    #1;
    chk("rp_pending_clr", pending, 0);
    chk("rp_fc_clr", fc, 0);
    chk("rp_seq_clr", seq_code, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (applied) seen++;
    end
    chk("rp_no_apply", seen, 0);
    chk("rp_fc_still0", fc, 0);
    chk("rp_pd_still0", pd, 0);
    chk("rp_flags", {code_bit, pending, err}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
